// File: rtl/regfl_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Sizes of the requester array, register select and register data.
package regfl_pkg;

   localparam int N_REQ  = 4;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 64;
   localparam int N_REGS = 8;
   localparam int PTR_W  = 2;

endpackage

// File: rtl/regfl_rf.sv
// 8 x 64-bit register file with one write port and one read port.
// Ports: clk, rst, we/s/d write; rd_s in, rd_d out (combinational).
module regfl_rf
   import regfl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] s,
   input  logic [DATA_W-1:0] d,
   input  logic [ADDR_W-1:0] rd_s,
   output logic [DATA_W-1:0] rd_d
);

   logic [DATA_W-1:0] mem_q [N_REGS];

   // contents survive reset; a write landing on a reset edge is dropped
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem_q[s] <= d;
      end
   end

   assign rd_d = mem_q[rd_s];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker over four requesters.
// Ports: req/ptr/en in; one-hot gnt, binary idx, any out.
module rr_pick
   import regfl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [PTR_W-1:0] pidx;
   logic             hit;

   always_comb begin
      // rotate so requester ptr sits at bit 0
      rot  = N_REQ'({req, req} >> ptr);
      pidx = '0;
      hit  = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pidx = PTR_W'(i);
            hit  = 1'b1;
         end
      end
      any = en & hit;
      // rotate back; 2-bit add wraps mod 4
      idx = pidx + ptr;
      gnt = any ? (N_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/regfl_wr_arb.sv
// Round-robin arbiter sharing the register file write port.
// Ports: clk, rst, req/req_addr/req_data, hold, rd_s in;
//        gnt, we, s, d, wr_valid, rd_d out.
module regfl_wr_arb
   import regfl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic                    hold,
   input  logic [ADDR_W-1:0]       rd_s,
   output logic [N_REQ-1:0]        gnt,
   output logic                    we,
   output logic [ADDR_W-1:0]       s,
   output logic [DATA_W-1:0]       d,
   output logic [N_REGS-1:0]       wr_valid,
   output logic [DATA_W-1:0]       rd_d
);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] s_q, s_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic [N_REGS-1:0] wv_q, wv_d;
   logic [PTR_W-1:0]  win_idx;
   logic              win_any;
   logic              pick_en;

   assign pick_en = !rst && !hold;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .en  (pick_en),
      .gnt (gnt),
      .idx (win_idx),
      .any (win_any)
   );

   always_comb begin
      ptr_d = ptr_q;
      we_d  = win_any;
      s_d   = s_q;
      d_d   = d_q;
      wv_d  = wv_q;
      if (win_any) begin
         s_d       = req_addr[win_idx*ADDR_W +: ADDR_W];
         d_d       = req_data[win_idx*DATA_W +: DATA_W];
         ptr_d     = win_idx + PTR_W'(1);
         wv_d[s_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         we_q  <= 1'b0;
         s_q   <= '0;
         d_q   <= '0;
         wv_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         we_q  <= we_d;
         s_q   <= s_d;
         d_q   <= d_d;
         wv_q  <= wv_d;
      end
   end

   assign we       = we_q;
   assign s        = s_q;
   assign d        = d_q;
   assign wr_valid = wv_q;

   regfl_rf u_rf (
      .clk  (clk),
      .rst  (rst),
      .we   (we_q),
      .s    (s_q),
      .d    (d_q),
      .rd_s (rd_s),
      .rd_d (rd_d)
   );

endmodule

// File: tb/tb_regfl_wr_arb.sv
// Scoreboard bench for regfl_wr_arb: random and directed requests.
// Reference model tracks pointer, in-flight write and register contents.
module tb_regfl_wr_arb;
   import regfl_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } cmd_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ*ADDR_W-1:0] req_addr = '0;
   logic [N_REQ*DATA_W-1:0] req_data = '0;
   logic                    hold = 1'b0;
   logic [ADDR_W-1:0]       rd_s = '0;
   logic [N_REQ-1:0]        gnt;
   logic                    we;
   logic [ADDR_W-1:0]       s;
   logic [DATA_W-1:0]       d;
   logic [N_REGS-1:0]       wr_valid;
   logic [DATA_W-1:0]       rd_d;

   regfl_wr_arb dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .hold     (hold),
      .rd_s     (rd_s),
      .gnt      (gnt),
      .we       (we),
      .s        (s),
      .d        (d),
      .wr_valid (wr_valid),
      .rd_d     (rd_d)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // requester state
   bit                r_v [N_REQ];
   logic [ADDR_W-1:0] r_a [N_REQ];
   logic [DATA_W-1:0] r_d [N_REQ];

   // reference model
   int                m_ptr = 0;
   bit                pend_v = 0;
   cmd_t              pend;
   logic [DATA_W-1:0] m_reg [N_REGS];
   bit                m_known [N_REGS];
   logic [N_REGS-1:0] m_wv = '0;
   int                last_w;
   int                gcount [N_REQ];
   cmd_t              exp_q [$];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int winner();
      for (int k = 0; k < N_REQ; k++) begin
         int j = (m_ptr + k) % N_REQ;
         if (r_v[j]) return j;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N_REQ; i++) begin
         req[i] = r_v[i];
         req_addr[i*ADDR_W +: ADDR_W] = r_a[i];
         req_data[i*DATA_W +: DATA_W] = r_d[i];
      end
   endtask

   task automatic set_req(int i, bit v, int a, logic [63:0] dat);
      r_v[i] = v;
      r_a[i] = ADDR_W'(a);
      r_d[i] = dat;
   endtask

   // one clock: check at negedge, then advance the model at posedge
   task automatic cycle(int rsel);
      int w;
      drive();
      rd_s = (rsel < 0) ? ADDR_W'($urandom_range(0, N_REGS - 1))
                        : ADDR_W'(rsel);
      @(negedge clk);
      #1;
      w = (rst || hold) ? -1 : winner();
      chk("gnt", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
      chk("we", 64'(we), 64'(pend_v));
      chk("wr_valid", 64'(wr_valid), 64'(m_wv));
      if (m_known[rd_s]) chk("rd_d", rd_d, m_reg[rd_s]);
      if (w >= 0) begin
         exp_q.push_back({r_a[w], r_d[w]});
         gcount[w]++;
      end
      last_w = w;
      @(posedge clk);
      if (rst) begin
         pend_v = 0;
         m_wv   = '0;
         m_ptr  = 0;
      end else begin
         if (pend_v) begin
            m_reg[pend.a]   = pend.d;
            m_known[pend.a] = 1;
         end
         pend_v = (w >= 0);
         if (w >= 0) begin
            pend       = {r_a[w], r_d[w]};
            m_ptr      = (w + 1) % N_REQ;
            m_wv[r_a[w]] = 1'b1;
         end
      end
      #1;
   endtask

   // monitor: every registered command must match the oldest grant
   always @(negedge clk) begin
      if (we) begin
         if (exp_q.size() == 0) begin
            chk("we_unexpected", 64'(we), 64'd0);
         end else begin
            cmd_t e;
            e = exp_q.pop_front();
            chk("s", 64'(s), 64'(e.a));
            chk("d", d, e.d);
         end
      end
   end

   initial begin
      for (int i = 0; i < N_REQ; i++) set_req(i, 0, 0, 64'd0);
      for (int k = 0; k < N_REGS; k++) m_known[k] = 0;

      // reset then idle
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(-1);
      cycle(-1);
      chk("s_rst", 64'(s), 64'd0);
      chk("d_rst", d, 64'd0);
      rst = 1'b0;
      cycle(-1);

      // single write from requester 2
      set_req(2, 1, 5, 64'hDEAD_BEEF_0123_4567);
      cycle(-1);
      chk("gnt_single", 64'(last_w), 64'd2);
      set_req(2, 0, 0, 64'd0);
      cycle(-1);
      cycle(5);
      chk("wv_single", 64'(wr_valid), 64'h20);
      chk("rd_single", rd_d, 64'hDEAD_BEEF_0123_4567);

      // fairness from ptr 0
      rst = 1'b1;
      cycle(-1);
      rst = 1'b0;
      for (int i = 0; i < N_REQ; i++) gcount[i] = 0;
      for (int i = 0; i < N_REQ; i++)
         set_req(i, 1, i, {$urandom, $urandom});
      for (int n = 0; n < 8; n++) begin
         cycle(-1);
         chk("rr_order", 64'(last_w), 64'(n % N_REQ));
         r_d[last_w] = {$urandom, $urandom};
      end
      for (int i = 0; i < N_REQ; i++) begin
         chk("rr_count", 64'(gcount[i]), 64'd2);
         set_req(i, 0, 0, 64'd0);
      end
      cycle(-1);

      // pointer skip: grant 1, then 0 and 1 from ptr 2
      rst = 1'b1;
      cycle(-1);
      rst = 1'b0;
      set_req(1, 1, 6, 64'h1111);
      cycle(-1);
      set_req(0, 1, 6, 64'h2222);
      set_req(1, 1, 6, 64'h3333);
      cycle(-1);
      chk("skip_first", 64'(last_w), 64'd0);
      set_req(0, 0, 0, 64'd0);
      cycle(-1);
      chk("skip_second", 64'(last_w), 64'd1);
      set_req(1, 0, 0, 64'd0);
      cycle(-1);
      cycle(6);
      chk("last_wins", rd_d, 64'h3333);

      // hold for 3 cycles
      set_req(3, 1, 2, 64'h4444);
      hold = 1'b1;
      for (int n = 0; n < 3; n++) cycle(-1);
      hold = 1'b0;
      cycle(-1);
      chk("hold_release", 64'(last_w), 64'd3);
      set_req(3, 0, 0, 64'd0);
      cycle(-1);

      // reset while a command is in flight
      set_req(0, 1, 3, 64'hAAAA);
      cycle(-1);
      set_req(0, 0, 0, 64'd0);
      cycle(-1);
      set_req(0, 1, 3, 64'hBBBB);
      cycle(-1);
      set_req(0, 0, 0, 64'd0);
      rst = 1'b1;
      cycle(-1);
      rst = 1'b0;
      cycle(3);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_wv", 64'(wr_valid), 64'd0);
      chk("rst_drop", rd_d, 64'hAAAA);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         hold = ($urandom_range(0, 4) == 0);
         rst  = ($urandom_range(0, 59) == 0);
         cycle(-1);
         for (int i = 0; i < N_REQ; i++) begin
            if (!r_v[i] || last_w == i) begin
               set_req(i, $urandom_range(0, 2) != 0,
                       $urandom_range(0, N_REGS - 1),
                       {$urandom, $urandom});
            end
         end
      end

      // drain
      hold = 1'b0;
      rst  = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_req(i, 0, 0, 64'd0);
      for (int n = 0; n < 3; n++) cycle(-1);
      chk("q_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
